// File: rtl/manchester_pkg.sv
// ============================================================================
// manchester_pkg: shared line-code constants, encoder state type and chip map.
// Revision 1.0
// ============================================================================
`default_nettype none

package manchester_pkg;

  // Framing constants shared with the preamble inserter upstream.
  localparam logic [7:0] PREAMBLE_PATTERN = 8'hAA;
  localparam logic [7:0] START_WORD       = 8'hD5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HI    = 2'd1,
    ST_LO    = 2'd2,
    ST_ABORT = 2'd3
  } enc_state_t;

  // Nibble bit 3 lands on chips[7:6]; chips[7] leaves the serializer first.
  function automatic logic [7:0] manchester_encode_nibble(input logic [3:0] nibble,
                                                          input logic       invert);
    logic [7:0] chips;
    chips = 8'h00;
    for (int i = 0; i < 4; i++) begin
      chips[2*i +: 2] = {~nibble[i], nibble[i]} ^ {2{invert}};
    end
    return chips;
  endfunction

endpackage

`default_nettype wire

// File: rtl/manchester_tx_encoder.sv
// ============================================================================
// manchester_tx_encoder: AXI-Stream bytes to 8-chip Manchester words, high
// nibble first, with idle/abort handling. Revision 1.0
// ============================================================================
`default_nettype none

module manchester_tx_encoder
  import manchester_pkg::*;
#(
  parameter bit INVERT     = 1'b0,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic       aclk,
  input  logic       aresetn,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  input  logic       s_axis_tlast,
  output logic [7:0] tx_data,
  output logic       tx_en,
  output logic       underrun
);

  localparam logic [7:0] IDLE_WORD = {8{IDLE_LEVEL}};

  enc_state_t state, state_nxt;

  logic [7:0] shift_byte, shift_byte_nxt;
  logic       shift_last, shift_last_nxt;
  logic [7:0] hold_byte, hold_byte_nxt;
  logic       hold_last, hold_last_nxt;
  logic       hold_valid, hold_valid_nxt;

  logic [7:0] tx_data_nxt;
  logic       tx_en_nxt;
  logic       underrun_pend, underrun_pend_nxt;
  logic       accept;

  assign s_axis_tready = !hold_valid;
  assign accept        = s_axis_tvalid && s_axis_tready;

  always_comb begin
    state_nxt         = state;
    shift_byte_nxt    = shift_byte;
    shift_last_nxt    = shift_last;
    hold_byte_nxt     = hold_byte;
    hold_last_nxt     = hold_last;
    hold_valid_nxt    = hold_valid;
    tx_data_nxt       = IDLE_WORD;
    tx_en_nxt         = 1'b0;
    underrun_pend_nxt = 1'b0;

    unique case (state)
      ST_IDLE: begin
        // A next-frame byte parked during the previous frame's last LO starts first.
        if (hold_valid) begin
          shift_byte_nxt = hold_byte;
          shift_last_nxt = hold_last;
          hold_valid_nxt = 1'b0;
          state_nxt      = ST_HI;
        end else if (accept) begin
          shift_byte_nxt = s_axis_tdata;
          shift_last_nxt = s_axis_tlast;
          state_nxt      = ST_HI;
        end
      end

      ST_HI: begin
        tx_data_nxt = manchester_encode_nibble(shift_byte[7:4], INVERT);
        tx_en_nxt   = 1'b1;
        if (accept) begin
          hold_byte_nxt  = s_axis_tdata;
          hold_last_nxt  = s_axis_tlast;
          hold_valid_nxt = 1'b1;
        end
        state_nxt = ST_LO;
      end

      ST_LO: begin
        tx_data_nxt = manchester_encode_nibble(shift_byte[3:0], INVERT);
        tx_en_nxt   = 1'b1;
        if (shift_last) begin
          if (accept) begin
            hold_byte_nxt  = s_axis_tdata;
            hold_last_nxt  = s_axis_tlast;
            hold_valid_nxt = 1'b1;
          end
          state_nxt = ST_IDLE;
        end else if (hold_valid) begin
          shift_byte_nxt = hold_byte;
          shift_last_nxt = hold_last;
          hold_valid_nxt = 1'b0;
          state_nxt      = ST_HI;
        end else if (s_axis_tvalid) begin
          shift_byte_nxt = s_axis_tdata;
          shift_last_nxt = s_axis_tlast;
          state_nxt      = ST_HI;
        end else begin
          underrun_pend_nxt = 1'b1;
          state_nxt         = ST_ABORT;
        end
      end

      ST_ABORT: begin
        if (accept && s_axis_tlast) begin
          state_nxt = ST_IDLE;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state         <= ST_IDLE;
      shift_byte    <= 8'h00;
      shift_last    <= 1'b0;
      hold_byte     <= 8'h00;
      hold_last     <= 1'b0;
      hold_valid    <= 1'b0;
      tx_data       <= IDLE_WORD;
      tx_en         <= 1'b0;
      underrun_pend <= 1'b0;
      underrun      <= 1'b0;
    end else begin
      state         <= state_nxt;
      shift_byte    <= shift_byte_nxt;
      shift_last    <= shift_last_nxt;
      hold_byte     <= hold_byte_nxt;
      hold_last     <= hold_last_nxt;
      hold_valid    <= hold_valid_nxt;
      tx_data       <= tx_data_nxt;
      tx_en         <= tx_en_nxt;
      // Delayed one edge so the pulse lines up with the first idle word.
      underrun_pend <= underrun_pend_nxt;
      underrun      <= underrun_pend;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_manchester_tx_encoder.sv
// ============================================================================
// tb_manchester_tx_encoder: scoreboard bench for manchester_tx_encoder.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_manchester_tx_encoder;

  logic       aclk;
  logic       aresetn;
  logic [7:0] s_axis_tdata;
  logic       s_axis_tvalid;
  logic       s_axis_tready;
  logic       s_axis_tlast;
  logic [7:0] tx_data;
  logic       tx_en;
  logic       underrun;

  logic       inv_aresetn;
  logic [7:0] inv_tdata;
  logic       inv_tvalid;
  logic       inv_tready;
  logic       inv_tlast;
  logic [7:0] inv_tx_data;
  logic       inv_tx_en;
  logic       inv_underrun;

  int checks   = 0;
  int failures = 0;
  int en_cycles = 0;
  int en_starts = 0;
  int und_cnt   = 0;
  bit prev_en   = 1'b0;
  logic [7:0] exp_q[$];

  manchester_tx_encoder #(.INVERT(1'b0), .IDLE_LEVEL(1'b0)) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .tx_data       (tx_data),
    .tx_en         (tx_en),
    .underrun      (underrun)
  );

  manchester_tx_encoder #(.INVERT(1'b1), .IDLE_LEVEL(1'b0)) dut_inv (
    .aclk          (aclk),
    .aresetn       (inv_aresetn),
    .s_axis_tdata  (inv_tdata),
    .s_axis_tvalid (inv_tvalid),
    .s_axis_tready (inv_tready),
    .s_axis_tlast  (inv_tlast),
    .tx_data       (inv_tx_data),
    .tx_en         (inv_tx_en),
    .underrun      (inv_underrun)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %02h expected %02h", tag, obs, exp);
    end
  endtask

  // Chip pair per bit: 1 -> 01, 0 -> 10 (before inversion), bit 3 first.
  function automatic logic [7:0] model_chips(input logic [3:0] n, input bit inv);
    logic [7:0] w;
    w = 8'h00;
    for (int i = 3; i >= 0; i--) w = {w[5:0], (n[i] ? 2'b01 : 2'b10)};
    if (inv) w = ~w;
    return w;
  endfunction

  always @(negedge aclk) begin
    if (!aresetn) begin
      prev_en = 1'b0;
    end else begin
      if (tx_en) begin
        en_cycles++;
        if (!prev_en) en_starts++;
        if (exp_q.size() == 0) check_eq("extra_word", {7'b0, tx_en}, 8'h00);
        else check_eq("word", tx_data, exp_q.pop_front());
      end else begin
        check_eq("idle_data", tx_data, 8'h00);
      end
      if (underrun) begin
        und_cnt++;
        check_eq("underrun_en", {7'b0, tx_en}, 8'h00);
        check_eq("underrun_prev_en", {7'b0, prev_en}, 8'h01);
      end
      prev_en = tx_en;
    end
  end

  task automatic send(input logic [7:0] d, input bit last, input bit expect_words, input int pre_idle);
    int n;
    if (pre_idle > 0) begin
      repeat (pre_idle) @(posedge aclk);
      #1;
    end
    s_axis_tdata  = d;
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
    n = 0;
    do begin
      @(negedge aclk);
      n++;
    end while (!s_axis_tready && n < 50);
    if (!s_axis_tready) check_eq("handshake_timeout", {7'b0, s_axis_tready}, 8'h01);
    @(posedge aclk);
    if (expect_words) begin
      exp_q.push_back(model_chips(d[7:4], 1'b0));
      exp_q.push_back(model_chips(d[3:0], 1'b0));
    end
    #1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic settle();
    repeat (6) @(posedge aclk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0, s0, u0;
    aresetn = 1'b0; inv_aresetn = 1'b0;
    s_axis_tdata = 8'h00; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    inv_tdata = 8'h00; inv_tvalid = 1'b0; inv_tlast = 1'b0;

    // Reset
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check_eq("rst_tx_data", tx_data, 8'h00);
    check_eq("rst_tx_en", {7'b0, tx_en}, 8'h00);
    check_eq("rst_underrun", {7'b0, underrun}, 8'h00);
    @(posedge aclk); #1;
    aresetn = 1'b1; inv_aresetn = 1'b1;
    @(negedge aclk);
    check_eq("rst_tready", {7'b0, s_axis_tready}, 8'h01);
    @(posedge aclk); #1;

    // Full frame, continuous valid
    c0 = en_cycles; s0 = en_starts; u0 = und_cnt;
    send(8'hAA, 1'b0, 1'b1, 0);
    send(8'hAA, 1'b0, 1'b1, 0);
    send(8'hD5, 1'b0, 1'b1, 0);
    send(8'h3C, 1'b1, 1'b1, 0);
    settle();
    check_eq("frame_en_cycles", 8'(en_cycles - c0), 8'd8);
    check_eq("frame_en_runs", 8'(en_starts - s0), 8'd1);
    check_eq("frame_no_underrun", 8'(und_cnt - u0), 8'd0);

    // Single byte frame
    c0 = en_cycles; s0 = en_starts;
    send(8'hF0, 1'b1, 1'b1, 0);
    settle();
    check_eq("single_en_cycles", 8'(en_cycles - c0), 8'd2);
    check_eq("single_en_runs", 8'(en_starts - s0), 8'd1);

    // Upstream stall during HI, next byte through the LO bypass
    c0 = en_cycles; s0 = en_starts; u0 = und_cnt;
    send(8'h12, 1'b0, 1'b1, 0);
    send(8'h34, 1'b0, 1'b1, 1);
    send(8'h5E, 1'b1, 1'b1, 1);
    settle();
    check_eq("stall_en_cycles", 8'(en_cycles - c0), 8'd6);
    check_eq("stall_en_runs", 8'(en_starts - s0), 8'd1);
    check_eq("stall_no_underrun", 8'(und_cnt - u0), 8'd0);

    // Underrun then abort-discard
    c0 = en_cycles; u0 = und_cnt;
    send(8'hAA, 1'b0, 1'b1, 0);
    repeat (4) @(posedge aclk);
    #1;
    check_eq("underrun_pulses", 8'(und_cnt - u0), 8'd1);
    @(negedge aclk);
    check_eq("abort_tready", {7'b0, s_axis_tready}, 8'h01);
    send(8'h11, 1'b0, 1'b0, 0);
    send(8'h22, 1'b1, 1'b0, 0);
    settle();
    check_eq("abort_en_cycles", 8'(en_cycles - c0), 8'd2);
    check_eq("abort_single_pulse", 8'(und_cnt - u0), 8'd1);
    c0 = en_cycles;
    send(8'h5A, 1'b1, 1'b1, 0);
    settle();
    check_eq("post_abort_en_cycles", 8'(en_cycles - c0), 8'd2);
    check_eq("queue_drained", 8'(exp_q.size()), 8'd0);

    // INVERT=1 encoder and mid-frame reset
    inv_tdata = 8'hA3; inv_tlast = 1'b0; inv_tvalid = 1'b1;
    @(negedge aclk);
    check_eq("inv_tready", {7'b0, inv_tready}, 8'h01);
    @(posedge aclk); #1;
    inv_tdata = 8'h77;
    @(posedge aclk); #1;
    inv_tvalid = 1'b0;
    @(negedge aclk);
    check_eq("inv_hi_word", inv_tx_data, model_chips(4'hA, 1'b1));
    check_eq("inv_hi_en", {7'b0, inv_tx_en}, 8'h01);
    @(posedge aclk); #1;
    inv_aresetn = 1'b0;
    @(negedge aclk);
    check_eq("inv_lo_word", inv_tx_data, model_chips(4'h3, 1'b1));
    @(negedge aclk);
    check_eq("inv_rst_data", inv_tx_data, 8'h00);
    check_eq("inv_rst_en", {7'b0, inv_tx_en}, 8'h00);
    check_eq("inv_rst_underrun", {7'b0, inv_underrun}, 8'h00);
    @(posedge aclk); #1;
    inv_aresetn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge aclk);
      check_eq("inv_post_underrun", {7'b0, inv_underrun}, 8'h00);
      check_eq("inv_post_en", {7'b0, inv_tx_en}, 8'h00);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
